// File: rtl/encrypt_packet_framer_if.sv
// Byte-stream bundle for the packet framer: encrypted input strobe plus the
// valid/ready framed output. The framer takes the slave view.
interface encrypt_packet_framer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sof;
   logic       out_eof;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_sof, out_eof
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_sof, out_eof
   );
endinterface

// File: rtl/encrypt_packet_framer.sv
// Buffers encrypted bytes and emits fixed-length frames: A5, length, payload, checksum.
// Define FRAMER_CRC8_EN for a CRC-8 (poly 0x07) checksum; otherwise the checksum is XOR.
//
// state | meaning
// IDLE  | no frame in flight, waiting for a full payload in the FIFO
// HDR   | presenting header byte 0xA5 with out_sof
// LEN   | presenting payload length byte
// PAY   | presenting FIFO head, popping one byte per handshake
// CSUM  | presenting checksum byte with out_eof
module encrypt_packet_framer #(
   parameter int DEPTH   = 16,
   parameter int PKT_LEN = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   encrypt_packet_framer_if.slave bus,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] PKT_LVL  = LW'(PKT_LEN);
   localparam logic [7:0]    LEN_BYTE = 8'(PKT_LEN);
   localparam logic [7:0]    LAST_IDX = 8'(PKT_LEN - 1);

   typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CSUM} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    pay_cnt;
   logic [7:0]    csum;
   logic [7:0]    csum_next;
   logic [7:0]    head;
   logic [7:0]    data_mux;
   logic          valid_q;
   logic          sof_q;
   logic          eof_q;
   logic          hs;
   logic          pop;
   logic          push;
   logic          full;

   assign head = mem[rd_ptr];
   assign hs   = valid_q && bus.out_ready;
   assign pop  = hs && (state == PAY);
   assign full = (level == FULL_LVL);
   // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
   assign push = bus.in_valid && (!full || pop);

`ifdef FRAMER_CRC8_EN
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction
   assign csum_next = crc8_byte(csum, head);
`else
   assign csum_next = csum ^ head;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (bus.in_valid && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         pay_cnt <= '0;
         csum    <= '0;
      end else begin
         case (state)
            IDLE: if (level >= PKT_LVL) begin
               state   <= HDR;
               valid_q <= 1'b1;
               sof_q   <= 1'b1;
               csum    <= '0;
            end
            HDR: if (hs) begin
               state <= LEN;
               sof_q <= 1'b0;
            end
            LEN: if (hs) begin
               state   <= PAY;
               pay_cnt <= '0;
            end
            PAY: if (hs) begin
               csum    <= csum_next;
               pay_cnt <= pay_cnt + 1'b1;
               if (pay_cnt == LAST_IDX) begin
                  state <= CSUM;
                  eof_q <= 1'b1;
               end
            end
            CSUM: if (hs) begin
               state   <= IDLE;
               valid_q <= 1'b0;
               eof_q   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output byte is a pure function of registered state, so it never follows out_ready.
   always_comb begin
      data_mux = 8'h00;
      case (state)
         HDR:     data_mux = 8'hA5;
         LEN:     data_mux = LEN_BYTE;
         PAY:     data_mux = head;
         CSUM:    data_mux = csum;
         default: data_mux = 8'h00;
      endcase
   end

   assign bus.out_valid = valid_q;
   assign bus.out_sof   = sof_q;
   assign bus.out_eof   = eof_q;
   assign bus.out_data  = data_mux;
endmodule

// File: doc/encrypt_packet_framer.md
# encrypt_packet_framer

Downstream consumer of the encryption system's encrypted byte stream (`encrypted_data`, `encrypted_data_valid`). It buffers encrypted bytes in a FIFO, then emits them as fixed-length frames over a valid/ready byte interface: a header byte, a length byte, `PKT_LEN` payload bytes, and a trailing checksum byte. The encrypt side has no backpressure, so FIFO overflow is detected and flagged rather than stalled.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO depth in bytes. Must be a power of 2 and at least `PKT_LEN`.
- `PKT_LEN`, default 8: payload bytes per frame, range 1..255.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte strobe; connects to `encrypted_data_valid`.
- `in_data` input 8: encrypted byte; connects to `encrypted_data`.
- `out_valid` output 1: frame byte available.
- `out_ready` input 1: sink accepts the byte when `out_valid` is high.
- `out_data` output 8: frame byte.
- `out_sof` output 1: high with the header byte.
- `out_eof` output 1: high with the checksum byte.
- `overflow` output 1: sticky; an input byte was dropped.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO write:** on `in_valid` at a clock edge, write `in_data` if the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, drop the byte and set `overflow`.
  - If a pop occurs in the same cycle, the write is accepted and `level` is unchanged.
- **FSM states:** IDLE, HDR, LEN, PAY, CSUM.
  - IDLE -> HDR when `level >= PKT_LEN`.
  - HDR -> LEN on handshake (`out_valid && out_ready`).
  - LEN -> PAY on handshake.
  - PAY pops one FIFO byte per handshake. After the `PKT_LEN`-th payload handshake, go to CSUM.
  - CSUM -> IDLE on handshake.
- **Output bytes per state:**
  - HDR: `out_data` = 0xA5, `out_sof` = 1.
  - LEN: `out_data` = `PKT_LEN[7:0]`.
  - PAY: `out_data` = FIFO head.
  - CSUM: `out_data` = checksum, `out_eof` = 1.
  - IDLE: `out_valid` = 0 and `out_data` = 0x00.
- **Frame start condition:** a frame starts only when the full payload is already buffered. PAY therefore never underflows, and `out_valid` never drops mid-frame.
- **Checksum:**
  - Cleared to 0x00 on entering HDR.
  - Updated with each payload byte at its handshake.
  - Default checksum is the XOR of all payload bytes.
- **Counters:** payload counter is 8 bits. FIFO pointers wrap modulo `DEPTH`.
- **Reset:** reset mid-frame aborts the frame and empties the FIFO; it does not finish the frame.
- **`overflow`:** cleared only by `rst`.

## Timing
- **Reset values:**
  - `out_valid`, `out_sof`, `out_eof`, `overflow` = 0.
  - `out_data` = 0x00, `level` = 0.
  - FSM = IDLE, FIFO empty.
- **`level` update:** updates on the edge that samples the write or pop.
- **Frame start latency:** if the byte that makes `level == PKT_LEN` is sampled at edge E, the FSM enters HDR at edge E+1, so `out_valid` is high in the cycle after E+1.
- **Output hold rules:**
  - `out_valid`, `out_data`, `out_sof`, `out_eof` are driven from registered state and FIFO head only.
  - They must not depend combinationally on `out_ready`.
  - They must hold stable until the handshake.
- **Back-to-back frames:** if `level >= PKT_LEN` when CSUM is accepted, the FSM passes through IDLE for exactly one cycle before HDR.
- **Full-rate throughput:** with `out_ready` held high, one frame byte is transferred per cycle, so a frame takes `PKT_LEN`+3 cycles.
- **Overflow timing:** `overflow` rises on the edge after the dropped byte is sampled.

## Configuration
- Macro `FRAMER_CRC8_EN`:
  - **Defined:** the checksum byte is CRC-8 instead of XOR. Polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR. Updated one byte per payload handshake (single-cycle combinational byte update).
  - **Undefined:** XOR checksum as above; no CRC logic is synthesized.
  - Ports and timing are identical in both builds.

## Test plan
- **Basic frame (XOR):** `PKT_LEN`=4, `out_ready`=1; write 0x01,0x02,0x03,0x04 on consecutive cycles. Expect A5 (`out_sof`), 04, 01, 02, 03, 04, 04 (`out_eof`, XOR). HDR appears on the second edge after the last write.
- **Basic frame (CRC):** same stimulus with `FRAMER_CRC8_EN` defined. Expect the checksum byte = 0xE3.
- **Backpressure:** toggle `out_ready` pseudo-randomly during a frame. Expect `out_data`/`out_valid` held stable while `out_ready`=0, no byte lost or duplicated, and a correct checksum.
- **Overflow:** `DEPTH`=16, `PKT_LEN`=8, `out_ready`=0; write 18 bytes. Expect `level`=16, `overflow`=1 after the 17th byte, and bytes 17–18 absent from later frames. Also write on a full FIFO in a cycle with a PAY pop: expect the write accepted and `overflow` unchanged.
- **Back-to-back frames:** write 16 bytes with `PKT_LEN`=8 and `out_ready`=1. Expect two complete frames with exactly one IDLE cycle between the first `out_eof` and the second `out_sof`.
- **Reset mid-frame:** assert `rst`=0 during PAY. Expect outputs at reset values immediately (asynchronous) and `level`=0. After release, the next frame starts only after `PKT_LEN` new writes.
